// File: rtl/riscv_run_ctrl.sv
// riscv_run_ctrl
// Run/step/breakpoint controller for the RISC-V core. Produces the core
// clock-enable and taps the fetch and writeback ports for board display.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   run_i/step_i/halt_i   single-cycle command pulses (halt > step > run)
//   step_n_i              step length, sampled on an accepted step_i
//   bp_en_i, bp_addr_i    fetch-address breakpoint
//   pc_i, rom_ce_i        core fetch address / fetch enable
//   wb_we_i/wd_i/wdata_i  core writeback port
//   core_en_o             core clock-enable
//   state_o, bp_hit_o     controller state (IDLE/RUN/STEP/BREAK), break flag
//   cycle_cnt_o, wb_cnt_o enabled-cycle and captured-writeback counters
//   last_waddr_o/wdata_o  last captured (non-x0) writeback
module riscv_run_ctrl #(
  parameter int unsigned STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_i,
  input  logic              step_i,
  input  logic              halt_i,
  input  logic [STEP_W-1:0] step_n_i,
  input  logic              bp_en_i,
  input  logic [31:0]       bp_addr_i,
  input  logic [31:0]       pc_i,
  input  logic              rom_ce_i,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_wd_i,
  input  logic [31:0]       wb_wdata_i,
  output logic              core_en_o,
  output logic [1:0]        state_o,
  output logic              bp_hit_o,
  output logic [31:0]       cycle_cnt_o,
  output logic [31:0]       wb_cnt_o,
  output logic [4:0]        last_waddr_o,
  output logic [31:0]       last_wdata_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STEP  = 2'b10,
    BREAK = 2'b11
  } state_t;

  state_t            state, state_nx;
  logic [STEP_W-1:0] step_cnt, step_cnt_nx;
  logic              skip, skip_nx;
  logic              bp_match;
  logic              step_ok;

  // skip suppresses the match for the first enabled cycle after leaving
  // BREAK, so the core executes the breakpoint instruction on resume.
  assign bp_match  = bp_en_i & rom_ce_i & (pc_i == bp_addr_i) & ~skip;
  assign core_en_o = ((state == RUN) || (state == STEP)) & ~bp_match;
  assign state_o   = state;
  assign bp_hit_o  = (state == BREAK);
  assign step_ok   = step_i & (step_n_i != '0);

  always_comb begin
    state_nx    = state;
    step_cnt_nx = step_cnt;
    skip_nx     = skip;
    if (core_en_o) skip_nx = 1'b0;
    case (state)
      IDLE: begin
        if (!halt_i) begin
          if (step_ok) begin
            state_nx    = STEP;
            step_cnt_nx = step_n_i;
          end else if (run_i) begin
            state_nx = RUN;
          end
        end
      end
      RUN: begin
        if (halt_i)        state_nx = IDLE;
        else if (bp_match) state_nx = BREAK;
      end
      STEP: begin
        if (halt_i) begin
          state_nx = IDLE;
        end else if (bp_match) begin
          state_nx = BREAK;
        end else begin
          // Not matching in STEP means this cycle is enabled.
          step_cnt_nx = step_cnt - STEP_W'(1);
          if (step_cnt == STEP_W'(1)) state_nx = IDLE;
        end
      end
      default: begin // BREAK
        if (halt_i) begin
          state_nx = IDLE;
        end else if (step_ok) begin
          state_nx    = STEP;
          step_cnt_nx = step_n_i;
          skip_nx     = 1'b1;
        end else if (run_i) begin
          state_nx = RUN;
          skip_nx  = 1'b1;
        end
      end
    endcase
    // Remaining step count is meaningless outside STEP; IDLE also drops skip.
    if (state_nx == IDLE) begin
      skip_nx     = 1'b0;
      step_cnt_nx = '0;
    end
    if (state_nx == BREAK) step_cnt_nx = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      step_cnt     <= '0;
      skip         <= 1'b0;
      cycle_cnt_o  <= '0;
      wb_cnt_o     <= '0;
      last_waddr_o <= '0;
      last_wdata_o <= '0;
    end else begin
      state    <= state_nx;
      step_cnt <= step_cnt_nx;
      skip     <= skip_nx;
      if (core_en_o) cycle_cnt_o <= cycle_cnt_o + 32'd1;
      if (wb_we_i && core_en_o && (wb_wd_i != '0)) begin
        last_waddr_o <= wb_wd_i;
        last_wdata_o <= wb_wdata_i;
        wb_cnt_o     <= wb_cnt_o + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Testbench for riscv_run_ctrl: directed vector table plus hand-written
// sequences for run start latency, breakpoint/resume and async reset.
module tb_riscv_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_i = 1'b0, step_i = 1'b0, halt_i = 1'b0;
  logic [7:0]  step_n_i = '0;
  logic        bp_en_i = 1'b0;
  logic [31:0] bp_addr_i = '0;
  logic [31:0] pc_i;
  logic        rom_ce_i = 1'b1;
  logic        wb_we_i = 1'b0;
  logic [4:0]  wb_wd_i = '0;
  logic [31:0] wb_wdata_i = '0;
  logic        core_en_o;
  logic [1:0]  state_o;
  logic        bp_hit_o;
  logic [31:0] cycle_cnt_o, wb_cnt_o, last_wdata_o;
  logic [4:0]  last_waddr_o;

  int checks = 0;
  int errors = 0;

  riscv_run_ctrl #(.STEP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run_i(run_i), .step_i(step_i), .halt_i(halt_i),
    .step_n_i(step_n_i), .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i),
    .pc_i(pc_i), .rom_ce_i(rom_ce_i), .wb_we_i(wb_we_i), .wb_wd_i(wb_wd_i),
    .wb_wdata_i(wb_wdata_i), .core_en_o(core_en_o), .state_o(state_o),
    .bp_hit_o(bp_hit_o), .cycle_cnt_o(cycle_cnt_o), .wb_cnt_o(wb_cnt_o),
    .last_waddr_o(last_waddr_o), .last_wdata_o(last_wdata_o)
  );

  always #5 clk = ~clk;

  // Minimal core fetch model: PC advances by 4 on every enabled cycle.
  always @(posedge clk or negedge rst_n)
    if (!rst_n)         pc_i <= 32'h0;
    else if (core_en_o) pc_i <= pc_i + 32'd4;

  typedef struct {
    logic        run, step, halt;
    logic [7:0]  n;
    logic        we;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        en;
    logic [1:0]  st;
    logic [31:0] cyc, wbc;
    logic [4:0]  la;
    logic [31:0] ld;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic r, logic s, logic h, logic [7:0] n,
                              logic we, logic [4:0] wd, logic [31:0] wdata,
                              logic en, logic [1:0] st, logic [31:0] cyc,
                              logic [31:0] wbc, logic [4:0] la, logic [31:0] ld);
    vec_t v;
    v.run = r; v.step = s; v.halt = h; v.n = n; v.we = we; v.wd = wd;
    v.wdata = wdata; v.en = en; v.st = st; v.cyc = cyc; v.wbc = wbc;
    v.la = la; v.ld = ld;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive command pulses for one cycle; outputs are checked 1ns later,
  // well before the next rising edge.
  task automatic tick(input logic r, input logic s, input logic h, input logic [7:0] n);
    @(negedge clk);
    run_i = r; step_i = s; halt_i = h; step_n_i = n; wb_we_i = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run_i = 0; step_i = 0; halt_i = 0; wb_we_i = 0; bp_en_i = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_en"},    {31'b0, core_en_o}, 32'd0);
    chk({tag, "_state"}, {30'b0, state_o},   32'd0);
    chk({tag, "_bphit"}, {31'b0, bp_hit_o},  32'd0);
    chk({tag, "_cyc"},   cycle_cnt_o,        32'd0);
    chk({tag, "_wbc"},   wb_cnt_o,           32'd0);
    chk({tag, "_la"},    {27'b0, last_waddr_o}, 32'd0);
    chk({tag, "_ld"},    last_wdata_o,       32'd0);
  endtask

  initial begin
    // Reset values, then run_i at cycle 5.
    do_reset();
    chk_reset("rst");
    for (int i = 1; i <= 5; i++) begin
      tick(i == 5, 1'b0, 1'b0, 8'd0);
      chk("run_lat_en0", {31'b0, core_en_o}, 32'd0);
    end
    for (int i = 6; i <= 15; i++) begin
      tick(1'b0, 1'b0, 1'b0, 8'd0);
      chk("run_en1", {31'b0, core_en_o}, 32'd1);
      chk("run_state", {30'b0, state_o}, 32'd1);
    end
    tick(1'b0, 1'b0, 1'b0, 8'd0);
    chk("run_cyc10", cycle_cnt_o, 32'd10);

    // Asynchronous reset between edges while running.
    #1 rst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table (run restart, writeback capture, step, halt, priority).
    tv.push_back(mk(0,0,0,0,  0,0,32'h0,         0,2'd0,0,0,0,32'h0));
    tv.push_back(mk(1,0,0,0,  0,0,32'h0,         0,2'd0,0,0,0,32'h0));
    tv.push_back(mk(0,0,0,0,  0,0,32'h0,         1,2'd1,0,0,0,32'h0));
    tv.push_back(mk(0,0,0,0,  1,5,32'hDEADBEEF,  1,2'd1,1,0,0,32'h0));
    tv.push_back(mk(0,0,0,0,  1,0,32'h1,         1,2'd1,2,1,5,32'hDEADBEEF));
    tv.push_back(mk(0,0,1,0,  1,7,32'h1234,      1,2'd1,3,1,5,32'hDEADBEEF));
    tv.push_back(mk(0,0,0,0,  0,0,32'h0,         0,2'd0,4,2,7,32'h1234));
    tv.push_back(mk(0,0,0,0,  1,9,32'h55,        0,2'd0,4,2,7,32'h1234));
    tv.push_back(mk(0,1,0,3,  0,0,32'h0,         0,2'd0,4,2,7,32'h1234));
    tv.push_back(mk(0,0,0,0,  0,0,32'h0,         1,2'd2,4,2,7,32'h1234));
    tv.push_back(mk(0,0,0,0,  0,0,32'h0,         1,2'd2,5,2,7,32'h1234));
    tv.push_back(mk(0,0,0,0,  0,0,32'h0,         1,2'd2,6,2,7,32'h1234));
    tv.push_back(mk(0,0,0,0,  0,0,32'h0,         0,2'd0,7,2,7,32'h1234));
    tv.push_back(mk(0,1,0,0,  0,0,32'h0,         0,2'd0,7,2,7,32'h1234));
    tv.push_back(mk(0,0,0,0,  0,0,32'h0,         0,2'd0,7,2,7,32'h1234));
    tv.push_back(mk(1,0,1,0,  0,0,32'h0,         0,2'd0,7,2,7,32'h1234));
    tv.push_back(mk(0,0,0,0,  0,0,32'h0,         0,2'd0,7,2,7,32'h1234));
    tv.push_back(mk(0,1,0,10, 0,0,32'h0,         0,2'd0,7,2,7,32'h1234));
    tv.push_back(mk(0,0,0,0,  0,0,32'h0,         1,2'd2,7,2,7,32'h1234));
    tv.push_back(mk(0,0,0,0,  0,0,32'h0,         1,2'd2,8,2,7,32'h1234));
    tv.push_back(mk(0,0,0,0,  0,0,32'h0,         1,2'd2,9,2,7,32'h1234));
    tv.push_back(mk(0,0,0,0,  0,0,32'h0,         1,2'd2,10,2,7,32'h1234));
    tv.push_back(mk(0,0,0,0,  0,0,32'h0,         1,2'd2,11,2,7,32'h1234));
    tv.push_back(mk(0,0,1,0,  0,0,32'h0,         1,2'd2,12,2,7,32'h1234));
    tv.push_back(mk(0,0,0,0,  0,0,32'h0,         0,2'd0,13,2,7,32'h1234));
    tv.push_back(mk(0,1,1,4,  0,0,32'h0,         0,2'd0,13,2,7,32'h1234));
    tv.push_back(mk(0,0,0,0,  0,0,32'h0,         0,2'd0,13,2,7,32'h1234));

    foreach (tv[i]) begin
      @(negedge clk);
      run_i = tv[i].run; step_i = tv[i].step; halt_i = tv[i].halt;
      step_n_i = tv[i].n; wb_we_i = tv[i].we; wb_wd_i = tv[i].wd;
      wb_wdata_i = tv[i].wdata;
      #1;
      chk($sformatf("v%0d_en", i),  {31'b0, core_en_o}, {31'b0, tv[i].en});
      chk($sformatf("v%0d_st", i),  {30'b0, state_o},   {30'b0, tv[i].st});
      chk($sformatf("v%0d_cyc", i), cycle_cnt_o,        tv[i].cyc);
      chk($sformatf("v%0d_wbc", i), wb_cnt_o,           tv[i].wbc);
      chk($sformatf("v%0d_la", i),  {27'b0, last_waddr_o}, {27'b0, tv[i].la});
      chk($sformatf("v%0d_ld", i),  last_wdata_o,       tv[i].ld);
    end

    // Breakpoint at 0x10, then resume past it.
    do_reset();
    bp_en_i = 1'b1;
    bp_addr_i = 32'h10;
    tick(1'b1, 1'b0, 1'b0, 8'd0);
    chk("bp_run_en0", {31'b0, core_en_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 1'b0, 8'd0);
      chk("bp_pre_en", {31'b0, core_en_o}, 32'd1);
      chk("bp_pre_pc", pc_i, 32'(4 * i));
    end
    tick(1'b0, 1'b0, 1'b0, 8'd0);
    chk("bp_match_pc", pc_i, 32'h10);
    chk("bp_match_en0", {31'b0, core_en_o}, 32'd0);
    chk("bp_match_state", {30'b0, state_o}, 32'd1);
    tick(1'b0, 1'b0, 1'b0, 8'd0);
    chk("bp_state", {30'b0, state_o}, 32'd3);
    chk("bp_hit", {31'b0, bp_hit_o}, 32'd1);
    chk("bp_hold_pc", pc_i, 32'h10);
    chk("bp_cyc", cycle_cnt_o, 32'd4);
    tick(1'b1, 1'b0, 1'b0, 8'd0);
    chk("bp_resume_en0", {31'b0, core_en_o}, 32'd0);
    tick(1'b0, 1'b0, 1'b0, 8'd0);
    chk("bp_resume_en1", {31'b0, core_en_o}, 32'd1);
    chk("bp_resume_pc", pc_i, 32'h10);
    chk("bp_resume_state", {30'b0, state_o}, 32'd1);
    tick(1'b0, 1'b0, 1'b0, 8'd0);
    chk("bp_past_pc", pc_i, 32'h14);
    chk("bp_past_en", {31'b0, core_en_o}, 32'd1);
    tick(1'b0, 1'b0, 1'b0, 8'd0);
    chk("bp_past2_pc", pc_i, 32'h18);
    chk("bp_past2_hit", {31'b0, bp_hit_o}, 32'd0);
    tick(1'b0, 1'b0, 1'b1, 8'd0);
    tick(1'b0, 1'b0, 1'b0, 8'd0);
    chk("bp_halt_state", {30'b0, state_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_run_ctrl.md
# riscv_run_ctrl

Run/step/breakpoint controller for the RISC-V core on the FPGA top level. Gates the core with a clock-enable, running freely, stepping a fixed number of enabled cycles, or freezing on a PC breakpoint. Taps the core's fetch address and writeback port to count executed cycles and latch the last register write for board display. Sits between the board-level buttons/switches and the `riscv` core instance, alongside `inst_rom`.

## Interface
- STEP_W, 8, width of step count input and internal step counter
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- run_i  input  1  single-cycle pulse: start free run
- step_i  input  1  single-cycle pulse: run step_n_i enabled cycles
- halt_i  input  1  single-cycle pulse: stop, return to IDLE
- step_n_i  input  STEP_W  step length in enabled cycles, sampled on accepted step_i
- bp_en_i  input  1  breakpoint enable
- bp_addr_i  input  32  breakpoint fetch address
- pc_i  input  32  core fetch address (rom_addr_o)
- rom_ce_i  input  1  core fetch enable (rom_ce_o)
- wb_we_i  input  1  core writeback enable
- wb_wd_i  input  5  core writeback register address
- wb_wdata_i  input  32  core writeback data
- core_en_o  output  1  core clock-enable; core holds all state when 0
- state_o  output  2  IDLE=00, RUN=01, STEP=10, BREAK=11
- bp_hit_o  output  1  high while in BREAK
- cycle_cnt_o  output  32  count of enabled cycles
- wb_cnt_o  output  32  count of captured writebacks
- last_waddr_o  output  5  address of last captured writeback
- last_wdata_o  output  32  data of last captured writeback

## Operation
- Reset: state IDLE, core_en_o 0, bp_hit_o 0, all counters and last_* 0, step counter 0, skip flag 0.
- Command priority when pulses coincide: halt_i > step_i > run_i.
- bp_match = bp_en_i & rom_ce_i & (pc_i == bp_addr_i) & ~skip.
- core_en_o = (state RUN or STEP) & ~bp_match; combinational.
- IDLE: run_i -> RUN. step_i with step_n_i != 0 -> STEP, step counter loads step_n_i. step_i with step_n_i == 0 ignored. halt_i no effect.
- RUN: halt_i -> IDLE. bp_match (no halt) -> BREAK.
- STEP: each cycle with core_en_o=1 decrements step counter. Enabled cycle with counter == 1 -> IDLE. halt_i -> IDLE. bp_match -> BREAK; remaining count discarded.
- BREAK: core frozen on matching PC. run_i -> RUN. step_i (step_n_i != 0) -> STEP. halt_i -> IDLE. Any exit sets skip=1.
- Skip flag:
  - Cleared on the first cycle with core_en_o=1.
  - Also cleared on entry to IDLE.
  - Purpose: resuming from BREAK executes past the breakpoint instead of re-matching immediately.
- cycle_cnt_o increments on every cycle with core_en_o=1; wraps 0xFFFFFFFF -> 0.
- Writeback capture on wb_we_i & core_en_o & (wb_wd_i != 0):
  - last_waddr_o <= wb_wd_i, last_wdata_o <= wb_wdata_i.
  - wb_cnt_o increments, wrapping at 32 bits.
  - Writes to x0 are never captured.
- Counters and last_* are cleared only by reset.

## Timing
- State, counters, and last_* are registered on the rising clk edge. core_en_o and bp_hit_o are derived from the registered state; core_en_o also from the bp_match comparison.
- Command pulse sampled at edge N: first enabled cycle is N+1. core_en_o rises one cycle after the run_i/step_i cycle.
- Step of n: core_en_o high for exactly n cycles, barring breakpoint/halt. state_o returns to IDLE on the edge ending the n-th enabled cycle.
- halt_i at edge N: core_en_o is 0 from cycle N+1. Cycle N itself is still enabled if the state allowed it.
- Breakpoint:
  - core_en_o drops in the same cycle pc_i matches, so the matching instruction is not fetched.
  - state_o = BREAK and bp_hit_o = 1 from the next cycle.
- Capture latency: last_* and wb_cnt_o update one cycle after the qualifying writeback cycle.
- Reset asserted mid-RUN/STEP: core_en_o drops asynchronously; all outputs take reset values immediately.

## Test plan
- Reset, then pulse run_i at cycle 5 -> core_en_o 0 through cycle 5, 1 from cycle 6; state_o = 01; cycle_cnt_o = 10 after 10 enabled cycles.
- From IDLE: step_i with step_n_i = 3 -> core_en_o high exactly 3 cycles; state_o back to 00; cycle_cnt_o += 3. Repeat with step_n_i = 0 -> no change.
- bp_en_i = 1, bp_addr_i = 0x10, then run -> core_en_o falls in the cycle pc_i = 0x10; state_o = 11, bp_hit_o = 1; pc_i holds 0x10. run_i again -> PC advances past 0x10 without re-break.
- Writeback of x5 = 0xDEADBEEF, then x0 = 0x1 -> last_waddr_o = 5, last_wdata_o = 0xDEADBEEF, wb_cnt_o = 1. Writeback with core_en_o = 0 is ignored.
- halt_i and run_i in the same cycle while IDLE -> stays IDLE. halt_i during STEP with 5 remaining -> IDLE next cycle, core_en_o 0.
- Assert rst_n low mid-RUN between clock edges -> core_en_o 0 and all counters 0 before the next edge; run_i after release restarts normally.
